// File: rtl/xy_led_guide_if.sv
// Coordinate sample bus from the blob tracker plus the guidance LED outputs.
// The tracker side drives x/y/valid; the LED guide drives the lamps.
interface xy_led_guide_if #(
   parameter int XW = 10,
   parameter int YW = 10
);
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          valid;
   logic          LED1;
   logic          LED2;
   logic          LED3;
   logic          LED4;
   logic          LED5;
   logic          tracking;

   modport master (
      output x, y, valid,
      input  LED1, LED2, LED3, LED4, LED5, tracking
   );

   modport slave (
      input  x, y, valid,
      output LED1, LED2, LED3, LED4, LED5, tracking
   );
endinterface

// File: rtl/xy_led_guide.sv
// Guidance LED driver: per-axis zone classification with centre deadband,
// debounce over consecutive present samples, and a lost-blob timeout with blinking centre LED.
module xy_led_guide #(
   parameter int XW           = 10,
   parameter int YW           = 10,
   parameter int RES_X        = 1024,
   parameter int RES_Y        = 768,
   parameter int DEADBAND     = 16,
   parameter int HOLD         = 3,
   parameter int LOST_CYCLES  = 1200000,
   parameter int BLINK_CYCLES = 3000000
) (
   input logic           clk,
   input logic           reset,
   xy_led_guide_if.slave bus
);
   typedef enum logic [1:0] {Z_CENTRE = 2'd0, Z_LOW = 2'd1, Z_HIGH = 2'd2} zone_t;
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_TRACK = 2'd1, S_LOST = 2'd2} state_t;

   localparam int MID_X = RES_X / 2;
   localparam int MID_Y = RES_Y / 2;
   localparam int CW    = $clog2(HOLD + 1);
   localparam int TW    = $clog2(LOST_CYCLES + 1);
   localparam int BW    = $clog2(BLINK_CYCLES + 1);

   // Index 0 is the x axis, index 1 the y axis.
   logic [31:0] coord [2];
   zone_t       zone  [2];
   logic        present;

   assign coord[0] = {{(32 - XW){1'b0}}, bus.x};
   assign coord[1] = {{(32 - YW){1'b0}}, bus.y};
   assign present  = bus.valid && (bus.y != '1);

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_zone
         localparam int          MID  = (gi == 0) ? MID_X : MID_Y;
         localparam int          RES  = (gi == 0) ? RES_X : RES_Y;
         localparam logic [31:0] LO_T = 32'(MID - DEADBAND);
         localparam logic [31:0] HI_T = 32'(MID + DEADBAND);
         localparam logic [31:0] RS_T = 32'(RES);
         assign zone[gi] = (coord[gi] >= RS_T) ? Z_HIGH :
                           (coord[gi] <  LO_T) ? Z_LOW  :
                           (coord[gi] >  HI_T) ? Z_HIGH : Z_CENTRE;
      end
   endgenerate

   state_t          state_reg, state_next;
   zone_t           cur_reg  [2];
   zone_t           cur_next [2];
   zone_t           cand_reg [2];
   zone_t           cand_next[2];
   logic [CW-1:0]   cnt_reg  [2];
   logic [CW-1:0]   cnt_next [2];
   logic [TW-1:0]   timer_reg, timer_next;
   logic [BW-1:0]   blink_cnt_reg, blink_cnt_next;
   logic            blink_reg, blink_next;

   logic            led1_reg, led2_reg, led3_reg, led4_reg, led5_reg, tracking_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         timer_reg     <= '0;
         blink_cnt_reg <= '0;
         blink_reg     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            cur_reg[i]  <= Z_CENTRE;
            cand_reg[i] <= Z_CENTRE;
            cnt_reg[i]  <= '0;
         end
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         blink_cnt_reg <= blink_cnt_next;
         blink_reg     <= blink_next;
         for (int i = 0; i < 2; i++) begin
            cur_reg[i]  <= cur_next[i];
            cand_reg[i] <= cand_next[i];
            cnt_reg[i]  <= cnt_next[i];
         end
      end
   end

   always_comb begin
      state_next     = state_reg;
      timer_next     = timer_reg;
      blink_cnt_next = blink_cnt_reg;
      blink_next     = blink_reg;
      for (int i = 0; i < 2; i++) begin
         cur_next[i]  = cur_reg[i];
         cand_next[i] = cand_reg[i];
         cnt_next[i]  = cnt_reg[i];
      end

      case (state_reg)
         S_TRACK: begin
            if (present) begin
               timer_next = '0;
               for (int i = 0; i < 2; i++) begin
                  if (zone[i] == cur_reg[i]) begin
                     cnt_next[i] = '0;
                  end else if (zone[i] == cand_reg[i]) begin
                     if (32'(cnt_reg[i]) + 32'd1 == 32'(HOLD)) begin
                        cur_next[i] = zone[i];
                        cnt_next[i] = '0;
                     end else begin
                        cnt_next[i] = cnt_reg[i] + 1'b1;
                     end
                  end else begin
                     cand_next[i] = zone[i];
                     cnt_next[i]  = CW'(1);
                     if (HOLD == 1) cur_next[i] = zone[i];
                  end
               end
            end else if (timer_reg == TW'(LOST_CYCLES - 1)) begin
               state_next     = S_LOST;
               blink_next     = 1'b1;
               blink_cnt_next = '0;
            end else begin
               timer_next = timer_reg + 1'b1;
            end
         end
         S_IDLE, S_LOST: begin
            // Reacquisition skips debounce: commit the sample zones directly.
            if (present) begin
               state_next = S_TRACK;
               timer_next = '0;
               for (int i = 0; i < 2; i++) begin
                  cur_next[i]  = zone[i];
                  cand_next[i] = zone[i];
                  cnt_next[i]  = '0;
               end
            end else if (state_reg == S_LOST) begin
               if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
                  blink_cnt_next = '0;
                  blink_next     = ~blink_reg;
               end else begin
                  blink_cnt_next = blink_cnt_reg + 1'b1;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Output stage registers the LED decode of the committed state.
   always_ff @(posedge clk) begin
      if (reset) begin
         led1_reg     <= 1'b0;
         led2_reg     <= 1'b0;
         led3_reg     <= 1'b0;
         led4_reg     <= 1'b0;
         led5_reg     <= 1'b0;
         tracking_reg <= 1'b0;
      end else begin
         tracking_reg <= (state_reg == S_TRACK);
         led1_reg     <= (state_reg == S_TRACK) && (cur_reg[0] == Z_LOW);
         led3_reg     <= (state_reg == S_TRACK) && (cur_reg[0] == Z_HIGH);
         led2_reg     <= (state_reg == S_TRACK) && (cur_reg[1] == Z_LOW);
         led4_reg     <= (state_reg == S_TRACK) && (cur_reg[1] == Z_HIGH);
         led5_reg     <= ((state_reg == S_TRACK) && (cur_reg[0] == Z_CENTRE) &&
                          (cur_reg[1] == Z_CENTRE)) ||
                         ((state_reg == S_LOST) && blink_reg);
      end
   end

   assign bus.LED1     = led1_reg;
   assign bus.LED2     = led2_reg;
   assign bus.LED3     = led3_reg;
   assign bus.LED4     = led4_reg;
   assign bus.LED5     = led5_reg;
   assign bus.tracking = tracking_reg;
endmodule

// File: tb/tb_xy_led_guide.sv
// Directed bench for xy_led_guide: zone table, debounce, timeout, blink and reset corners.
module tb_xy_led_guide;
   logic clk;
   logic reset;
   int   checks;
   int   errors;

   xy_led_guide_if #(.XW(10), .YW(10)) bus ();

   xy_led_guide #(
      .XW(10), .YW(10), .RES_X(1024), .RES_Y(768), .DEADBAND(16), .HOLD(3),
      .LOST_CYCLES(100), .BLINK_CYCLES(10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] x;
      logic [9:0] y;
      logic [5:0] exp;   // {tracking, LED5, LED4, LED3, LED2, LED1}
   } vec_t;

   vec_t vecs [12];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [9:0] sx, input logic [9:0] sy);
      bus.x     = sx;
      bus.y     = sy;
      bus.valid = 1'b1;
      tick();
      bus.valid = 1'b0;
   endtask

   task automatic absent();
      bus.y     = '1;
      bus.valid = 1'b1;
      tick();
      bus.valid = 1'b0;
   endtask

   task automatic check(input string name, input logic [5:0] exp);
      logic [5:0] got;
      got = {bus.tracking, bus.LED5, bus.LED4, bus.LED3, bus.LED2, bus.LED1};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got trk/L5..L1=%b expected %b", name, got, exp);
      end else begin
         $display("ok   %s: trk/L5..L1=%b", name, got);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      vecs[0]  = '{10'd496,  10'd384,  6'b110000};
      vecs[1]  = '{10'd528,  10'd384,  6'b110000};
      vecs[2]  = '{10'd495,  10'd384,  6'b100001};
      vecs[3]  = '{10'd529,  10'd384,  6'b100100};
      vecs[4]  = '{10'd1023, 10'd384,  6'b100100};
      vecs[5]  = '{10'd512,  10'd367,  6'b100010};
      vecs[6]  = '{10'd512,  10'd368,  6'b110000};
      vecs[7]  = '{10'd512,  10'd400,  6'b110000};
      vecs[8]  = '{10'd512,  10'd401,  6'b101000};
      vecs[9]  = '{10'd0,    10'd0,    6'b100011};
      vecs[10] = '{10'd1023, 10'd767,  6'b101100};
      vecs[11] = '{10'd512,  10'd1022, 6'b111000 & 6'b101000};

      // Reset wins over a simultaneous valid sample.
      reset     = 1'b1;
      bus.valid = 1'b1;
      bus.x     = 10'd100;
      bus.y     = 10'd100;
      repeat (3) tick();
      check("reset_with_valid", 6'b000000);
      reset     = 1'b0;
      bus.valid = 1'b0;
      tick();
      check("idle_after_reset", 6'b000000);
      sample(10'd100, 10'd100);
      tick();
      check("first_load", 6'b100011);

      // Zone table: three agreeing samples always commit a zone.
      for (int v = 0; v < 12; v++) begin
         repeat (3) sample(vecs[v].x, vecs[v].y);
         tick();
         check($sformatf("zone_x%0d_y%0d", vecs[v].x, vecs[v].y), vecs[v].exp);
      end

      // Debounce: an interrupted run does not commit; a full run does.
      repeat (3) sample(10'd512, 10'd384);
      tick();
      check("deb_centre", 6'b110000);
      sample(10'd900, 10'd384);
      sample(10'd900, 10'd384);
      sample(10'd512, 10'd384);
      tick();
      check("deb_broken_run", 6'b110000);
      repeat (3) sample(10'd900, 10'd384);
      check("deb_not_yet", 6'b110000);
      tick();
      check("deb_commit", 6'b100100);

      // Absent samples only: LOST after 100 clocks, blink every 10.
      repeat (3) sample(10'd512, 10'd384);
      for (int k = 1; k <= 130; k++) begin
         absent();
         if (k == 100) check("lost_edge_still_track", 6'b110000);
         if (k > 100) begin
            logic ph;
            ph = (((k - 101) / 10) % 2) == 0;
            check($sformatf("lost_blink_k%0d", k), {1'b0, ph, 4'b0000});
         end
      end
      sample(10'd100, 10'd700);
      tick();
      check("reacquire_direct", 6'b101001);

      // Present sample on the timeout cycle keeps TRACK and clears the timer.
      repeat (3) sample(10'd512, 10'd384);
      repeat (99) tick();
      sample(10'd512, 10'd384);
      tick();
      check("timeout_cycle_sample", 6'b110000);
      repeat (99) tick();
      check("timer_cleared", 6'b110000);
      tick();
      check("lost_after_cleared", 6'b010000);

      // Reset mid-debounce, then first sample loads directly.
      sample(10'd512, 10'd384);
      sample(10'd900, 10'd384);
      sample(10'd900, 10'd384);
      reset     = 1'b1;
      bus.valid = 1'b1;
      bus.x     = 10'd900;
      tick();
      check("reset_mid_debounce", 6'b000000);
      reset     = 1'b0;
      bus.valid = 1'b0;
      tick();
      check("idle_after_reset2", 6'b000000);
      sample(10'd900, 10'd384);
      tick();
      check("load_after_reset", 6'b100100);

      // Reset while LOST.
      repeat (101) tick();
      check("lost_before_reset", 6'b010000);
      reset = 1'b1;
      tick();
      check("reset_in_lost", 6'b000000);
      reset = 1'b0;
      sample(10'd100, 10'd700);
      tick();
      check("load_after_lost_reset", 6'b101001);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
